priority_encoder_pipe: RTL
==========================

# priority_encoder_pipe

Parametrised, registered successor to the team's 8-bit one-hot encoder. Encodes a WIDTH-bit request vector into a binary index under one of four run-time modes: LSB-first priority, MSB-first priority, strict one-hot, and round-robin. Uses valid/ready handshakes on both sides. Sits between request sources (interrupt lines, arbiter requests) and index-consuming logic.

## Interface
- WIDTH, default 8: request vector width; legal range 2..64.
- CODE_W, default $clog2(WIDTH): index width; derived, never overridden.
- Clk  in  1  sole clock; all state updates on the rising edge.
- Rst_n  in  1  reset, asynchronous assert, active-low.
- Data  in  WIDTH  request vector; bit i requests index i.
- Mode  in  2  0 = LSB-first, 1 = MSB-first, 2 = strict one-hot, 3 = round-robin; sampled with Data.
- In_valid  in  1  Data/Mode valid.
- In_ready  out  1  block can accept this cycle.
- Code  out  CODE_W  encoded index.
- Hit  out  1  at least one Data bit was set.
- Err  out  1  strict mode only: Data was not exactly one-hot.
- Out_valid  out  1  Code/Hit/Err valid.
- Out_ready  in  1  consumer accepts.

## Operation
- **Accept.** A transfer occurs when In_valid && In_ready. In_ready = !Out_valid || Out_ready, which gives a single-entry pipeline that sustains full throughput.
- **Per-mode results on accept.** All results are written to the output register:
  - Mode 0: Code = lowest set bit index.
  - Mode 1: Code = highest set bit index.
  - Mode 2: if exactly one bit is set, Code = its index and Err = 0. Otherwise Code = 0 and Err = 1; this includes Data = 0.
  - Mode 3: Code = first set bit at or above the internal pointer Ptr, wrapping from WIDTH-1 to 0.
- **Zero input.** If Data == 0: Hit = 0 and Code = 0 in every mode. In Mode 2, Err = 1.
- **Err in other modes.** Err = 0 in modes 0, 1 and 3.
- **Round-robin pointer (Ptr, CODE_W bits).**
  - Updates only on an accepted Mode 3 transfer with Hit = 1.
  - New value is Ptr = Code + 1. If Code == WIDTH-1, Ptr wraps to 0.
  - Ptr holds on all other transfers, including those in other modes.
- **Output register.**
  - Out_valid is set by an accept.
  - Out_valid is cleared by Out_ready when no new accept occurs in the same cycle.
  - While Out_valid && !Out_ready, Code/Hit/Err hold stable.
- **Simultaneous events.** When an accept and a drain happen in the same cycle, the register loads the new result and Out_valid stays 1.
- **Reset, including mid-operation.** Out_valid = 0, Code = 0, Hit = 0, Err = 0, Ptr = 0. Any pending output is discarded. In_ready = 1 during reset.

## Timing
- Latency is 1 cycle: data accepted at edge N appears on Code/Hit/Err with Out_valid = 1 after edge N.
- Throughput is 1 transfer per cycle while Out_ready = 1.
- In_ready is combinational from Out_valid and Out_ready. There are no other input-to-output combinational paths.
- Mode may change on every transfer, with no penalty.

## Structure
- Package `encoder_pkg` holds:
  - the mode constants MODE_LSB, MODE_MSB, MODE_ONEHOT, MODE_RR (2-bit localparams);
  - a function for the one-hot count check, shared by future encoder variants.
- Sub-module `prio_find` (combinational, parameter WIDTH):
  - inputs: vector, start index, direction;
  - outputs: index, found.
  - Instantiated once. Modes 0, 1 and 3 all map onto it (start = 0 LSB-up, start = WIDTH-1 MSB-down, start = Ptr LSB-up with wrap).
- Top level holds the handshake register, Ptr, and the mode mux.

## Test plan
- **Mode 0, Data = 8'b0010_1100, Out_ready = 1.** Code = 2, Hit = 1, Err = 0, Out_valid one cycle after accept.
- **Mode 1, same Data.** Code = 5. Then Mode 2 with Data = 8'b0100_0000 gives Code = 6, Err = 0. Then Mode 2 with Data = 8'b0100_0001 gives Code = 0, Err = 1.
- **Mode 3, Data = 8'b1000_1001 held for 4 transfers.** Codes 0, 3, 7, 0. Ptr after each transfer: 1, 4, 0 (wrap), 1.
- **Data = 0 in each mode.** Hit = 0, Code = 0. Err = 1 only in Mode 2. Ptr unchanged in Mode 3.
- **Backpressure.** Hold Out_ready = 0 for 3 cycles after a result: In_ready = 0, outputs stable, no second accept. Then Out_ready = 1 with In_valid = 1: drain and accept in the same cycle, Out_valid stays 1.
- **Reset mid-operation.** Assert Rst_n = 0 with Out_valid = 1 and Ptr = 5: all outputs go to 0 immediately (asynchronously). After release, Mode 3 with Data = 8'hFF gives Code = 0.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder family: mode codes and a one-hot check.
package encoder_pkg;

  localparam logic [1:0] MODE_LSB    = 2'd0;
  localparam logic [1:0] MODE_MSB    = 2'd1;
  localparam logic [1:0] MODE_ONEHOT = 2'd2;
  localparam logic [1:0] MODE_RR     = 2'd3;

  // True when exactly one bit of the (zero-extended) vector is set.
  function automatic logic is_onehot(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n = n + 32'(v[i]);
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational first-set-bit search starting at an arbitrary index, wrapping
// around the vector, scanning upward (dir = 0) or downward (dir = 1).
module prio_find #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  vec,
  input  logic [CODE_W-1:0] start,
  input  logic              dir,
  output logic [CODE_W-1:0] idx,
  output logic              found
);

  // Walk WIDTH positions from start; the first set bit wins.
  always_comb begin
    int pos;
    pos   = 0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      pos = dir ? int'(start) - k : int'(start) + k;
      if (pos >= WIDTH) begin
        pos = pos - WIDTH;
      end else if (pos < 0) begin
        pos = pos + WIDTH;
      end
      if (!found && vec[CODE_W'(pos)]) begin
        found = 1'b1;
        idx   = CODE_W'(pos);
      end
    end
  end

endmodule

// File: rtl/priority_encoder_pipe.sv
// Registered multi-mode priority encoder with valid/ready on both sides.
// A single output register gives one-cycle latency and full throughput.
module priority_encoder_pipe
  import encoder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CODE_W = $clog2(WIDTH)  // derived; do not override
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  data,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] code,
  output logic              hit,
  output logic              err,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [CODE_W-1:0] ptr_q, ptr_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              hit_q, hit_d;
  logic              err_q, err_d;
  logic              valid_q;

  logic [CODE_W-1:0] find_start;
  logic              find_dir;
  logic [CODE_W-1:0] find_idx;
  logic              find_found;
  logic              accept;

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign code      = code_q;
  assign hit       = hit_q;
  assign err       = err_q;
  assign out_valid = valid_q;

  // Map the mode onto the shared search engine's start point and direction.
  always_comb begin
    find_start = '0;
    find_dir   = 1'b0;
    case (mode)
      MODE_MSB: begin
        find_start = CODE_W'(WIDTH - 1);
        find_dir   = 1'b1;
      end
      MODE_RR:  find_start = ptr_q;
      default:  find_start = '0;
    endcase
  end

  prio_find #(
    .WIDTH  (WIDTH),
    .CODE_W (CODE_W)
  ) u_find (
    .vec   (data),
    .start (find_start),
    .dir   (find_dir),
    .idx   (find_idx),
    .found (find_found)
  );

  // Result to load on accept; strict mode reports non-one-hot as an error.
  always_comb begin
    hit_d  = find_found;
    err_d  = 1'b0;
    code_d = find_found ? find_idx : '0;
    if (mode == MODE_ONEHOT) begin
      err_d  = !is_onehot(64'(data));
      code_d = err_d ? '0 : find_idx;
    end
  end

  // Round-robin pointer advances past the granted index, wrapping at WIDTH-1.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && (mode == MODE_RR) && find_found) begin
      ptr_d = (find_idx == CODE_W'(WIDTH - 1)) ? '0 : find_idx + CODE_W'(1);
    end
  end

  // Output register: load on accept, drop valid when drained without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        valid_q <= 1'b1;
        code_q  <= code_d;
        hit_q   <= hit_d;
        err_q   <= err_d;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
